// File: rtl/sd_wb_pkg.sv
// Shared types and helpers for the Wishbone slave memory.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sd_wb_pkg;

  localparam int WB_DW = 32;

  // IDLE waits for a request, WAIT burns wait states, RESP is the termination cycle.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } wb_state_t;

  // Expand the 4 Wishbone byte-lane enables into a 32-bit bit mask.
  function automatic logic [WB_DW-1:0] sel_to_mask(input logic [3:0] sel);
    logic [WB_DW-1:0] m;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = {8{sel[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/sd_wb_sp_ram.sv
// Single-port 32-bit RAM with byte-lane write enables plus a combinational backdoor read port.
// Latency: write commits on the edge; read data appears one edge after the address; backdoor is zero-latency.
// Backpressure: none, accepts an access every cycle.
module sd_wb_sp_ram
  import sd_wb_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [3:0]        sel,
  input  logic [ADDR_W-1:0] adr,
  input  logic [WB_DW-1:0]  wdat,
  output logic [WB_DW-1:0]  rdat,
  input  logic [ADDR_W-1:0] bd_adr,
  output logic [WB_DW-1:0]  bd_dat
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [WB_DW-1:0] mem [DEPTH];
  logic [WB_DW-1:0] mask;

  assign mask   = sel_to_mask(sel);
  assign bd_dat = mem[bd_adr];

  // Byte-masked write and registered read; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[adr] <= (mem[adr] & ~mask) | (wdat & mask);
    end
    rdat <= mem[adr];
  end

endmodule

// File: rtl/sd_wb_slave_mem.sv
// Wishbone classic slave memory with window decode, programmable wait states and transfer counters.
// Latency: ack/err is high 1 + WAIT_CYCLES + wait_i cycles after the accepting edge, for exactly one cycle.
// Backpressure: stalls the master by withholding ack; dropping cyc/stb during wait states aborts silently.
module sd_wb_slave_mem
  import sd_wb_pkg::*;
#(
  parameter int          ADDR_W      = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n_i,
  input  logic [31:0]       wb_adr_i,
  input  logic [31:0]       wb_dat_i,
  input  logic [3:0]        wb_sel_i,
  input  logic              wb_we_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  output logic [31:0]       wb_dat_o,
  output logic              wb_ack_o,
  output logic              wb_err_o,
  input  logic [3:0]        wait_i,
  output logic [15:0]       rd_cnt_o,
  output logic [15:0]       wr_cnt_o,
  input  logic [ADDR_W-1:0] bd_adr_i,
  output logic [31:0]       bd_dat_o
);

  wb_state_t         state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [4:0]        load_cnt;
  logic              req;
  logic              in_idle;
  logic              hit_now;
  logic              go_resp;

  // Request captured at acceptance, used while waiting.
  logic [ADDR_W-1:0] adr_q;
  logic              we_q;
  logic [3:0]        sel_q;
  logic [WB_DW-1:0]  dat_q;
  logic              hit_q;

  // Request as seen on the edge that enters RESP: live bus when coming
  // straight from IDLE, captured copy when coming from WAIT.
  logic [ADDR_W-1:0] cur_adr;
  logic              cur_we;
  logic [3:0]        cur_sel;
  logic [WB_DW-1:0]  cur_dat;
  logic              cur_hit;

  logic              ack_q, err_q, rd_vld_q;
  logic [15:0]       rd_cnt_q, wr_cnt_q;
  logic [WB_DW-1:0]  ram_rdat;
  logic              ram_we;

  // Byte offset bits carry no information for a word-wide memory.
  logic [1:0]        unused_adr;
  assign unused_adr = wb_adr_i[1:0];

  assign req      = wb_cyc_i & wb_stb_i;
  assign in_idle  = (state_q == ST_IDLE);
  assign hit_now  = (wb_adr_i[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
  assign load_cnt = 5'(WAIT_CYCLES) + {1'b0, wait_i};

  assign cur_adr  = in_idle ? wb_adr_i[ADDR_W+1:2] : adr_q;
  assign cur_we   = in_idle ? wb_we_i  : we_q;
  assign cur_sel  = in_idle ? wb_sel_i : sel_q;
  assign cur_dat  = in_idle ? wb_dat_i : dat_q;
  assign cur_hit  = in_idle ? hit_now  : hit_q;

  assign ram_we   = go_resp & cur_hit & cur_we;

  // Next-state and wait-state counter; abort has priority over completing the wait.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    go_resp = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          cnt_d = load_cnt;
          if (load_cnt == 5'd0) begin
            state_d = ST_RESP;
            go_resp = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!req) begin
          state_d = ST_IDLE;
        end else if (cnt_q == 5'd1) begin
          state_d = ST_RESP;
          go_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and wait counter registers.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture the request when it is accepted in IDLE.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      adr_q <= '0;
      we_q  <= 1'b0;
      sel_q <= 4'd0;
      dat_q <= '0;
      hit_q <= 1'b0;
    end else if (in_idle && req) begin
      adr_q <= wb_adr_i[ADDR_W+1:2];
      we_q  <= wb_we_i;
      sel_q <= wb_sel_i;
      dat_q <= wb_dat_i;
      hit_q <= hit_now;
    end
  end

  // Termination pulses; they self-clear because go_resp is never asserted in RESP.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      rd_vld_q <= 1'b0;
    end else begin
      ack_q    <= go_resp & cur_hit;
      err_q    <= go_resp & ~cur_hit;
      rd_vld_q <= go_resp & cur_hit & ~cur_we;
    end
  end

  // Saturating completion counters, bumped only on acked transfers.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      rd_cnt_q <= 16'd0;
      wr_cnt_q <= 16'd0;
    end else if (go_resp && cur_hit) begin
      if (cur_we && (wr_cnt_q != 16'hFFFF)) begin
        wr_cnt_q <= wr_cnt_q + 16'd1;
      end
      if (!cur_we && (rd_cnt_q != 16'hFFFF)) begin
        rd_cnt_q <= rd_cnt_q + 16'd1;
      end
    end
  end

  sd_wb_sp_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk    (wb_clk_i),
    .we     (ram_we),
    .sel    (cur_sel),
    .adr    (cur_adr),
    .wdat   (cur_dat),
    .rdat   (ram_rdat),
    .bd_adr (bd_adr_i),
    .bd_dat (bd_dat_o)
  );

  // RAM output is unreset, so gate it: data only shows during a read ack.
  assign wb_dat_o = rd_vld_q ? ram_rdat : '0;
  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;
  assign rd_cnt_o = rd_cnt_q;
  assign wr_cnt_o = wr_cnt_q;

endmodule

// File: tb/tb_sd_wb_slave_mem.sv
// Bench for sd_wb_slave_mem: one instance with no fixed wait states, one with two.
// Expected terminations are queued by the driver and retired by a monitor.
module tb_sd_wb_slave_mem;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   adr, wdat;
  logic [3:0]    sel, wait_v;
  logic          we, stb, cyc0, cyc1;
  logic [AW-1:0] bd_adr;

  logic [31:0]   dat0, dat1, bd_dat0, bd_dat1;
  logic          ack0, ack1, err0, err1;
  logic [15:0]   rd_cnt0, rd_cnt1, wr_cnt0, wr_cnt1;

  always #5 clk = ~clk;

  sd_wb_slave_mem #(.ADDR_W(AW), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) dut0 (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wb_adr_i(adr), .wb_dat_i(wdat),
    .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc0), .wb_stb_i(stb),
    .wb_dat_o(dat0), .wb_ack_o(ack0), .wb_err_o(err0), .wait_i(wait_v),
    .rd_cnt_o(rd_cnt0), .wr_cnt_o(wr_cnt0), .bd_adr_i(bd_adr), .bd_dat_o(bd_dat0)
  );

  sd_wb_slave_mem #(.ADDR_W(AW), .BASE_ADDR(32'h0), .WAIT_CYCLES(2)) dut1 (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wb_adr_i(adr), .wb_dat_i(wdat),
    .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc1), .wb_stb_i(stb),
    .wb_dat_o(dat1), .wb_ack_o(ack1), .wb_err_o(err1), .wait_i(wait_v),
    .rd_cnt_o(rd_cnt1), .wr_cnt_o(wr_cnt1), .bd_adr_i(bd_adr), .bd_dat_o(bd_dat1)
  );

  typedef struct {
    bit          dut;
    bit          is_err;
    bit          chk_dat;
    logic [31:0] dat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_fail = 0;
  logic prev_t0 = 1'b0;
  logic prev_t1 = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Monitor: retire one expected item per termination pulse.
  always @(negedge clk) begin
    if ((ack0 | err0 | ack1 | err1) === 1'b1) begin
      check("ack_err_excl", {31'd0, (ack0 & err0) | (ack1 & err1)}, 32'd0);
      check("term_gap", {30'd0, prev_t1 & (ack1 | err1), prev_t0 & (ack0 | err0)}, 32'd0);
      if (sb.size() == 0) begin
        check("spurious_term", {28'd0, err1, ack1, err0, ack0}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("term_dut", {31'd0, ack1 | err1}, {31'd0, mon_e.dut});
        check("term_is_err", {31'd0, mon_e.dut ? err1 : err0}, {31'd0, mon_e.is_err});
        if (mon_e.chk_dat) check("rd_data", mon_e.dut ? dat1 : dat0, mon_e.dat);
      end
    end
    prev_t0 = (ack0 | err0) === 1'b1;
    prev_t1 = (ack1 | err1) === 1'b1;
  end

  // One classic transfer on the chosen instance; checks acceptance-to-ack latency.
  task automatic xfer(input bit d, input bit w, input logic [31:0] a, input logic [31:0] v,
                      input logic [3:0] s, input logic [3:0] wt, input int exp_lat,
                      input bit exp_err, input logic [31:0] exp_rd);
    exp_t e;
    int   k;
    bit   term;
    e.dut     = d;
    e.is_err  = exp_err;
    e.chk_dat = exp_err | !w;
    e.dat     = exp_err ? 32'd0 : exp_rd;
    sb.push_back(e);
    @(negedge clk);
    adr = a; wdat = v; sel = s; we = w; wait_v = wt; stb = 1'b1;
    if (d) cyc1 = 1'b1; else cyc0 = 1'b1;
    @(posedge clk);
    k = 1;
    term = 1'b0;
    while (!term && k < 40) begin
      @(negedge clk);
      term = d ? ((ack1 | err1) === 1'b1) : ((ack0 | err0) === 1'b1);
      if (!term) begin
        @(posedge clk);
        k++;
      end
    end
    check("latency", k, exp_lat);
    if (!term && sb.size() > 0) void'(sb.pop_back());
    cyc0 = 1'b0; cyc1 = 1'b0; stb = 1'b0; we = 1'b0; wait_v = 4'd0;
  endtask

  initial begin
    rst_n = 1'b0; cyc0 = 1'b0; cyc1 = 1'b0; stb = 1'b0; we = 1'b0;
    adr = '0; wdat = '0; sel = '0; wait_v = '0; bd_adr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack", {31'd0, ack0}, 32'd0);
    check("rst_err", {31'd0, err0}, 32'd0);
    check("rst_dat", dat0, 32'd0);
    check("rst_rd_cnt", {16'd0, rd_cnt0}, 32'd0);
    check("rst_wr_cnt", {16'd0, wr_cnt0}, 32'd0);
    rst_n = 1'b1;

    // Write then read back, no wait states.
    xfer(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 4'd0, 1, 0, 32'h0);
    xfer(0, 0, 32'h10, 32'h0,        4'hF, 4'd0, 1, 0, 32'hDEADBEEF);
    @(negedge clk); bd_adr = 10'd4; #1;
    check("wr_cnt_a", {16'd0, wr_cnt0}, 32'd1);
    check("rd_cnt_a", {16'd0, rd_cnt0}, 32'd1);
    check("bd_word4", bd_dat0, 32'hDEADBEEF);

    // Byte lanes, then runtime wait states on the same word.
    xfer(0, 1, 32'h20, 32'h11223344, 4'hF,    4'd0, 1, 0, 32'h0);
    xfer(0, 1, 32'h20, 32'hAABBCCDD, 4'b0101, 4'd0, 1, 0, 32'h0);
    xfer(0, 0, 32'h20, 32'h0,        4'hF,    4'd0, 1, 0, 32'h11BB33DD);
    xfer(0, 1, 32'h20, 32'hFFFFFFFF, 4'b0000, 4'd0, 1, 0, 32'h0);
    xfer(0, 0, 32'h20, 32'h0,        4'hF,    4'd2, 3, 0, 32'h11BB33DD);
    @(negedge clk);
    check("wr_cnt_b", {16'd0, wr_cnt0}, 32'd4);
    check("rd_cnt_b", {16'd0, rd_cnt0}, 32'd3);

    // Out of window: 0x1000 aliases word 0 if the tag compare is broken.
    xfer(0, 1, 32'h0,    32'h5A5A0000, 4'hF, 4'd0, 1, 0, 32'h0);
    xfer(0, 1, 32'h1000, 32'hFFFFFFFF, 4'hF, 4'd0, 1, 1, 32'h0);
    xfer(0, 0, 32'h1000, 32'h0,        4'hF, 4'd0, 1, 1, 32'h0);
    @(negedge clk); bd_adr = 10'd0; #1;
    check("bd_word0", bd_dat0, 32'h5A5A0000);
    check("wr_cnt_c", {16'd0, wr_cnt0}, 32'd5);
    check("rd_cnt_c", {16'd0, rd_cnt0}, 32'd3);

    // Abort during wait states: no termination, no write, no count.
    @(negedge clk);
    adr = 32'h10; wdat = 32'h12345678; sel = 4'hF; we = 1'b1; wait_v = 4'd4; stb = 1'b1; cyc0 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    stb = 1'b0; cyc0 = 1'b0; we = 1'b0; wait_v = 4'd0;
    repeat (8) @(negedge clk);
    bd_adr = 10'd4; #1;
    check("abort_mem", bd_dat0, 32'hDEADBEEF);
    check("abort_wr_cnt", {16'd0, wr_cnt0}, 32'd5);
    xfer(0, 0, 32'h10, 32'h0, 4'hF, 4'd0, 1, 0, 32'hDEADBEEF);

    // Fixed plus runtime wait states on the second instance.
    xfer(1, 1, 32'h30, 32'hCAFEF00D, 4'hF, 4'd3, 6, 0, 32'h0);
    xfer(1, 0, 32'h30, 32'h0,        4'hF, 4'd3, 6, 0, 32'hCAFEF00D);
    xfer(1, 0, 32'h30, 32'h0,        4'hF, 4'd0, 3, 0, 32'hCAFEF00D);
    @(negedge clk); bd_adr = 10'd12; #1;
    check("bd1_word12", bd_dat1, 32'hCAFEF00D);
    check("wr_cnt1", {16'd0, wr_cnt1}, 32'd1);
    check("rd_cnt1", {16'd0, rd_cnt1}, 32'd2);

    // Reset while waiting; memory survives, next read is normal.
    @(negedge clk);
    adr = 32'h10; sel = 4'hF; we = 1'b0; wait_v = 4'd6; stb = 1'b1; cyc0 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0; #1;
    check("mid_rst_ack", {31'd0, ack0}, 32'd0);
    check("mid_rst_err", {31'd0, err0}, 32'd0);
    check("mid_rst_rd_cnt", {16'd0, rd_cnt0}, 32'd0);
    check("mid_rst_wr_cnt", {16'd0, wr_cnt0}, 32'd0);
    stb = 1'b0; cyc0 = 1'b0; wait_v = 4'd0;
    @(negedge clk);
    rst_n = 1'b1;
    xfer(0, 0, 32'h10, 32'h0, 4'hF, 4'd0, 1, 0, 32'hDEADBEEF);
    @(negedge clk); bd_adr = 10'd4; #1;
    check("post_rst_rd_cnt", {16'd0, rd_cnt0}, 32'd1);
    check("post_rst_bd", bd_dat0, 32'hDEADBEEF);

    repeat (4) @(negedge clk);
    check("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
